// File: rtl/inst_fetcher.sv
// ---------------------------------------------------------------------------
// inst_fetcher
//
// Instruction fetch front-end. Holds the PC, issues one word fetch at a time
// to the memory controller, and pushes {inst, pc, predicted next pc} into a
// circular instruction queue that the decoder pops. A flush from commit
// redirects the PC and empties the queue.
//
// Optional feature: define FETCH_JAL_PREDICT_EN to predict JAL targets
// (next fetch = pc + J-immediate). Without it every prediction is pc+4.
//
// Ports:
//   clk           system clock
//   rst           asynchronous, active-low reset
//   rdy           global ready; when low all state is frozen
//   clr           flush/redirect from commit stage
//   clr_pc        redirect target, valid with clr
//   inst_in_flg   fetch request to memory controller (registered)
//   inst_addr     fetch address (registered)
//   mem_ret_flg   memory controller returned an instruction word
//   mem_ret_data  returned instruction word
//   iq_pop        decoder consumes head entry
//   iq_empty      queue empty
//   iq_full       queue full
//   iq_inst       head instruction
//   iq_pc         head PC
//   iq_pred_pc    head predicted next PC
// ---------------------------------------------------------------------------
module inst_fetcher #(
    parameter int          IQ_DEPTH_LOG = 4,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clr,
    input  logic [31:0] clr_pc,
    output logic        inst_in_flg,
    output logic [31:0] inst_addr,
    input  logic        mem_ret_flg,
    input  logic [31:0] mem_ret_data,
    input  logic        iq_pop,
    output logic        iq_empty,
    output logic        iq_full,
    output logic [31:0] iq_inst,
    output logic [31:0] iq_pc,
    output logic [31:0] iq_pred_pc
);

    localparam int unsigned           DEPTH    = 1 << IQ_DEPTH_LOG;
    localparam logic [IQ_DEPTH_LOG:0] FULL_CNT = {1'b1, {IQ_DEPTH_LOG{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_GAP
    } state_t;

    state_t                  state, state_nxt;
    logic [31:0]             pc, pc_nxt;
    logic                    req_nxt;
    logic [31:0]             addr_nxt;
    logic                    push;
    logic                    pop_ok;
    logic [31:0]             npc;

    logic [IQ_DEPTH_LOG-1:0] head, tail;
    logic [IQ_DEPTH_LOG:0]   count;
    logic [31:0]             mem_inst [DEPTH];
    logic [31:0]             mem_pc   [DEPTH];
    logic [31:0]             mem_pred [DEPTH];

    // ------------------------------------------------------------------
    // Next-PC prediction
    // ------------------------------------------------------------------
    logic [31:0] seq_pc;
    assign seq_pc = pc + 32'd4;

`ifdef FETCH_JAL_PREDICT_EN
    logic        is_jal;
    logic [31:0] jal_off;
    assign is_jal  = (mem_ret_data[6:0] == 7'b1101111);
    assign jal_off = {{11{mem_ret_data[31]}}, mem_ret_data[31], mem_ret_data[19:12],
                      mem_ret_data[20], mem_ret_data[30:21], 1'b0};
    assign npc     = is_jal ? (pc + jal_off) : seq_pc;
`else
    assign npc     = seq_pc;
`endif

    // ------------------------------------------------------------------
    // Fetch FSM: next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        req_nxt   = inst_in_flg;
        addr_nxt  = inst_addr;
        push      = 1'b0;
        if (clr) begin
            // Flush wins over everything; GAP gives the controller a low cycle
            // before the first request at the new target.
            state_nxt = S_GAP;
            pc_nxt    = clr_pc;
            req_nxt   = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // One request outstanding at most, issued only with a free
                    // slot, so the matching push can never overflow.
                    if (count < FULL_CNT) begin
                        req_nxt   = 1'b1;
                        addr_nxt  = pc;
                        state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_ret_flg) begin
                        push      = 1'b1;
                        pc_nxt    = npc;
                        req_nxt   = 1'b0;
                        state_nxt = S_GAP;
                    end
                end
                S_GAP:   state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign pop_ok = iq_pop && (count != '0) && !clr;

    // ------------------------------------------------------------------
    // Fetch FSM: state and request registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            inst_in_flg <= 1'b0;
            inst_addr   <= RESET_PC;
        end else if (rdy) begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            inst_in_flg <= req_nxt;
            inst_addr   <= addr_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Instruction queue
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_inst[i] <= '0;
                mem_pc[i]   <= '0;
                mem_pred[i] <= '0;
            end
        end else if (rdy) begin
            if (clr) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    mem_inst[tail] <= mem_ret_data;
                    mem_pc[tail]   <= pc;
                    mem_pred[tail] <= npc;
                    tail           <= tail + 1'b1;
                end
                if (pop_ok) begin
                    head <= head + 1'b1;
                end
                case ({push, pop_ok})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    assign iq_empty   = (count == '0);
    assign iq_full    = (count == FULL_CNT);
    assign iq_inst    = mem_inst[head];
    assign iq_pc      = mem_pc[head];
    assign iq_pred_pc = mem_pred[head];

endmodule

// File: tb/tb_inst_fetcher.sv
// ---------------------------------------------------------------------------
// tb_inst_fetcher
//
// Self-checking bench for inst_fetcher. The bench plays the memory controller
// and keeps a scoreboard of expected queue entries, pushed when a return is
// driven and popped when the decoder side pops.
// Honors FETCH_JAL_PREDICT_EN for the expected predicted PC.
// ---------------------------------------------------------------------------
module tb_inst_fetcher;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        clr = 1'b0;
    logic [31:0] clr_pc = '0;
    logic        mem_ret_flg = 1'b0;
    logic [31:0] mem_ret_data = '0;
    logic        iq_pop = 1'b0;
    logic        inst_in_flg;
    logic [31:0] inst_addr;
    logic        iq_empty, iq_full;
    logic [31:0] iq_inst, iq_pc, iq_pred_pc;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pred;
    } ent_t;

    ent_t        sb[$];
    logic [31:0] m_pc;

`ifdef FETCH_JAL_PREDICT_EN
    localparam logic [31:0] JAL_PRED = 32'h108;
`else
    localparam logic [31:0] JAL_PRED = 32'h104;
`endif

    always #5 clk = ~clk;

    inst_fetcher #(
        .IQ_DEPTH_LOG (4),
        .RESET_PC     (32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .clr          (clr),
        .clr_pc       (clr_pc),
        .inst_in_flg  (inst_in_flg),
        .inst_addr    (inst_addr),
        .mem_ret_flg  (mem_ret_flg),
        .mem_ret_data (mem_ret_data),
        .iq_pop       (iq_pop),
        .iq_empty     (iq_empty),
        .iq_full      (iq_full),
        .iq_inst      (iq_inst),
        .iq_pc        (iq_pc),
        .iq_pred_pc   (iq_pred_pc)
    );

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_npc(input logic [31:0] p, input logic [31:0] d);
        logic [31:0] step;
        step = 32'd4;
`ifdef FETCH_JAL_PREDICT_EN
        if (d[6:0] == 7'h6F) begin
            logic [20:0] imm;
            imm  = {d[31], d[19:12], d[20], d[30:21], 1'b0};
            step = {{11{imm[20]}}, imm};
        end
`endif
        return p + step;
    endfunction

    function automatic ent_t sb_head();
        if (sb.size() > 0) return sb[0];
        return '0;
    endfunction

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (inst_in_flg === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Waits for a request, holds it lat cycles, then returns d for one cycle.
    task automatic serve(input logic [31:0] d, input int lat, output bit ok, output logic [31:0] addr);
        ent_t e;
        wait_req(ok);
        addr = inst_addr;
        if (!ok) return;
        repeat (lat) tick();
        mem_ret_flg  = 1'b1;
        mem_ret_data = d;
        e.inst = d;
        e.pc   = m_pc;
        e.pred = model_npc(m_pc, d);
        sb.push_back(e);
        m_pc = e.pred;
        tick();
        mem_ret_flg  = 1'b0;
        mem_ret_data = 32'hDEAD_BEEF;
    endtask

    task automatic pop_one();
        iq_pop = 1'b1;
        if (sb.size() > 0) void'(sb.pop_front());
        tick();
        iq_pop = 1'b0;
    endtask

    task automatic do_flush(input logic [31:0] target);
        clr    = 1'b1;
        clr_pc = target;
        tick();
        clr = 1'b0;
        sb.delete();
        m_pc = target;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        checks++;
        if (inst_in_flg !== 1'b0 || inst_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_req flg=%b addr=%h want 0/00000000", inst_in_flg, inst_addr);
        end
        checks++;
        if (iq_empty !== 1'b1 || iq_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags empty=%b full=%b want 1/0", iq_empty, iq_full);
        end
        checks++;
        if (iq_inst !== 32'h0 || iq_pc !== 32'h0 || iq_pred_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_head %h/%h/%h want 0/0/0", iq_inst, iq_pc, iq_pred_pc);
        end
        tick();
        tick();
        checks++;
        if (inst_in_flg !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold flg=%b want 0", inst_in_flg);
        end
        rst  = 1'b1;
        m_pc = 32'h0;
        sb.delete();
    endtask

    task automatic test_basic();
        bit ok;
        logic [31:0] a;
        serve(32'h0000_0013, 4, ok, a);
        checks++;
        if (!ok || a !== 32'h0) begin
            errors++;
            $display("FAIL basic_req0 ok=%b addr=%h want 00000000", ok, a);
        end
        checks++;
        if (inst_in_flg !== 1'b0) begin
            errors++;
            $display("FAIL basic_gap flg=%b want 0", inst_in_flg);
        end
        checks++;
        if (iq_inst !== 32'h13 || iq_pc !== 32'h0 || iq_pred_pc !== 32'h4) begin
            errors++;
            $display("FAIL basic_head0 %h/%h/%h want 00000013/00000000/00000004", iq_inst, iq_pc, iq_pred_pc);
        end
        serve(32'h0010_0093, 4, ok, a);
        checks++;
        if (!ok || a !== 32'h4) begin
            errors++;
            $display("FAIL basic_req1 ok=%b addr=%h want 00000004", ok, a);
        end
        pop_one();
        checks++;
        if (iq_empty !== 1'b0 || iq_inst !== 32'h0010_0093 || iq_pc !== 32'h4 || iq_pred_pc !== 32'h8) begin
            errors++;
            $display("FAIL basic_head1 e=%b %h/%h/%h want 0 00100093/00000004/00000008", iq_empty, iq_inst, iq_pc, iq_pred_pc);
        end
        pop_one();
        checks++;
        if (iq_empty !== 1'b1) begin
            errors++;
            $display("FAIL basic_drain empty=%b want 1", iq_empty);
        end
    endtask

    task automatic test_full();
        bit ok;
        bit seen;
        logic [31:0] a;
        ent_t h;
        do_flush(32'h0);
        for (int i = 0; i < 16; i++) begin
            serve(32'h0000_0013, 1, ok, a);
            checks++;
            if (!ok || a !== 32'(i * 4)) begin
                errors++;
                $display("FAIL full_req%0d ok=%b addr=%h want %h", i, ok, a, 32'(i * 4));
            end
        end
        checks++;
        if (iq_full !== 1'b1 || iq_empty !== 1'b0) begin
            errors++;
            $display("FAIL full_flag full=%b empty=%b want 1/0", iq_full, iq_empty);
        end
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (inst_in_flg !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL full_no_req saw request=1 want 0");
        end
        h = sb_head();
        checks++;
        if (iq_inst !== h.inst || iq_pc !== h.pc || iq_pred_pc !== h.pred) begin
            errors++;
            $display("FAIL full_head %h/%h/%h want %h/%h/%h", iq_inst, iq_pc, iq_pred_pc, h.inst, h.pc, h.pred);
        end
        pop_one();
        checks++;
        if (iq_full !== 1'b0) begin
            errors++;
            $display("FAIL full_after_pop full=%b want 0", iq_full);
        end
        wait_req(ok);
        checks++;
        if (!ok || inst_addr !== 32'h40) begin
            errors++;
            $display("FAIL full_resume ok=%b addr=%h want 00000040", ok, inst_addr);
        end
    endtask

    task automatic test_flush();
        // DUT is in WAIT at 0x40 with a full-minus-one queue.
        clr          = 1'b1;
        clr_pc       = 32'h200;
        mem_ret_flg  = 1'b1;
        mem_ret_data = 32'h0000_0013;
        iq_pop       = 1'b1;
        tick();
        clr         = 1'b0;
        mem_ret_flg = 1'b0;
        iq_pop      = 1'b0;
        sb.delete();
        m_pc = 32'h200;
        checks++;
        if (iq_empty !== 1'b1 || inst_in_flg !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear empty=%b flg=%b want 1/0", iq_empty, inst_in_flg);
        end
        tick();
        checks++;
        if (inst_in_flg !== 1'b0) begin
            errors++;
            $display("FAIL flush_gap flg=%b want 0", inst_in_flg);
        end
        tick();
        checks++;
        if (inst_in_flg !== 1'b1 || inst_addr !== 32'h200) begin
            errors++;
            $display("FAIL flush_redirect flg=%b addr=%h want 1/00000200", inst_in_flg, inst_addr);
        end
    endtask

    task automatic test_push_pop();
        bit ok;
        logic [31:0] a;
        ent_t e;
        ent_t h;
        serve(32'h0000_1113, 1, ok, a);
        serve(32'h0000_2213, 2, ok, a);
        serve(32'h0000_3313, 1, ok, a);
        wait_req(ok);
        checks++;
        if (!ok || inst_addr !== m_pc) begin
            errors++;
            $display("FAIL pp_req ok=%b addr=%h want %h", ok, inst_addr, m_pc);
        end
        tick();
        // Return and pop together at count=3.
        mem_ret_flg  = 1'b1;
        mem_ret_data = 32'h0000_4413;
        iq_pop       = 1'b1;
        e.inst = 32'h0000_4413;
        e.pc   = m_pc;
        e.pred = model_npc(m_pc, 32'h0000_4413);
        sb.push_back(e);
        m_pc = e.pred;
        void'(sb.pop_front());
        tick();
        mem_ret_flg = 1'b0;
        iq_pop      = 1'b0;
        h = sb_head();
        checks++;
        if (iq_empty !== 1'b0 || iq_inst !== h.inst || iq_pc !== h.pc || iq_pred_pc !== h.pred) begin
            errors++;
            $display("FAIL pp_head e=%b %h/%h/%h want 0 %h/%h/%h", iq_empty, iq_inst, iq_pc, iq_pred_pc, h.inst, h.pc, h.pred);
        end
        for (int i = 0; i < 3; i++) begin
            h = sb_head();
            checks++;
            if (iq_empty !== 1'b0 || iq_inst !== h.inst || iq_pc !== h.pc) begin
                errors++;
                $display("FAIL pp_drain%0d e=%b %h/%h want 0 %h/%h", i, iq_empty, iq_inst, iq_pc, h.inst, h.pc);
            end
            pop_one();
        end
        checks++;
        if (iq_empty !== 1'b1) begin
            errors++;
            $display("FAIL pp_count empty=%b want 1", iq_empty);
        end
        iq_pop = 1'b1;
        tick();
        iq_pop = 1'b0;
        checks++;
        if (iq_empty !== 1'b1 || iq_full !== 1'b0) begin
            errors++;
            $display("FAIL pop_empty empty=%b full=%b want 1/0", iq_empty, iq_full);
        end
        serve(32'h0000_5513, 1, ok, a);
        h = sb_head();
        checks++;
        if (iq_empty !== 1'b0 || iq_inst !== h.inst || iq_pc !== h.pc) begin
            errors++;
            $display("FAIL pop_empty_after e=%b %h/%h want 0 %h/%h", iq_empty, iq_inst, iq_pc, h.inst, h.pc);
        end
        pop_one();
    endtask

    task automatic test_rdy();
        bit ok;
        bit bad;
        logic [31:0] a;
        logic [31:0] held;
        wait_req(ok);
        held = inst_addr;
        checks++;
        if (!ok || held !== m_pc) begin
            errors++;
            $display("FAIL rdy_req ok=%b addr=%h want %h", ok, held, m_pc);
        end
        rdy = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_ret_flg  = (i % 2 == 0);
            mem_ret_data = 32'h0000_0055;
            tick();
            if (inst_in_flg !== 1'b1 || inst_addr !== held || iq_empty !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL rdy_freeze flg=%b addr=%h empty=%b want 1/%h/1", inst_in_flg, inst_addr, iq_empty, held);
        end
        rdy         = 1'b1;
        mem_ret_flg = 1'b0;
        serve(32'h0000_7713, 2, ok, a);
        checks++;
        if (!ok || a !== held || iq_pc !== held || iq_inst !== 32'h0000_7713) begin
            errors++;
            $display("FAIL rdy_resume ok=%b addr=%h pc=%h inst=%h want %h/%h/00007713", ok, a, iq_pc, iq_inst, held, held);
        end
        pop_one();
    endtask

    task automatic test_jal();
        bit ok;
        logic [31:0] a;
        do_flush(32'h100);
        serve(32'h0080_006F, 1, ok, a);
        checks++;
        if (!ok || a !== 32'h100 || iq_pc !== 32'h100) begin
            errors++;
            $display("FAIL jal_req ok=%b addr=%h pc=%h want 00000100", ok, a, iq_pc);
        end
        checks++;
        if (iq_pred_pc !== JAL_PRED) begin
            errors++;
            $display("FAIL jal_pred got %h want %h", iq_pred_pc, JAL_PRED);
        end
        wait_req(ok);
        checks++;
        if (!ok || inst_addr !== JAL_PRED) begin
            errors++;
            $display("FAIL jal_next ok=%b addr=%h want %h", ok, inst_addr, JAL_PRED);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [31:0] a;
        do_flush(32'hFFFF_FFFC);
        serve(32'h0000_0013, 1, ok, a);
        checks++;
        if (!ok || a !== 32'hFFFF_FFFC || iq_pred_pc !== 32'h0) begin
            errors++;
            $display("FAIL wrap_pred ok=%b addr=%h pred=%h want FFFFFFFC/00000000", ok, a, iq_pred_pc);
        end
        wait_req(ok);
        checks++;
        if (!ok || inst_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_next ok=%b addr=%h want 00000000", ok, inst_addr);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_flush();
        test_push_pop();
        test_rdy();
        test_jal();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete want finish");
        $fatal(1);
    end

endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
- Instruction fetch front-end that sits directly upstream of the memory controller's instruction-read port.
- Holds the PC and issues one word-fetch request at a time.
- Accepts the returned 32-bit instruction and pushes {inst, pc, predicted next pc} into a circular instruction queue, which the decoder/issue stage pops.
- A flush from the commit stage redirects the PC and empties the queue.

Parameters:
- IQ_DEPTH_LOG, 4, log2 of instruction-queue depth (16 entries).
- RESET_PC, 32'h0, PC value loaded on reset.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- rdy  input  1  global ready; when low, all state is frozen
- clr  input  1  flush/redirect from commit stage
- clr_pc  input  32  redirect target, valid with clr
- inst_in_flg  output  1  fetch request to memory controller (registered)
- inst_addr  output  32  fetch address (registered)
- mem_ret_flg  input  1  memory controller returned instruction word
- mem_ret_data  input  32  returned instruction word
- iq_pop  input  1  decoder consumes head entry
- iq_empty  output  1  queue empty
- iq_full  output  1  queue full
- iq_inst  output  32  head instruction
- iq_pc  output  32  head PC
- iq_pred_pc  output  32  head predicted next PC

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, state=IDLE, inst_in_flg=0, inst_addr=RESET_PC.
  - head=tail=0, count=0, iq_empty=1, iq_full=0.
  - iq_inst/iq_pc/iq_pred_pc=0.
- rdy=0: no state or output register changes; inputs are ignored.
- State machine (rdy=1, clr=0):
  - IDLE: if count<DEPTH, then inst_in_flg<=1, inst_addr<=pc, go to WAIT. Otherwise stay; inst_in_flg stays 0.
  - WAIT: inst_in_flg and inst_addr are held stable. On mem_ret_flg=1, push entry {mem_ret_data, pc, npc}, pc<=npc, inst_in_flg<=0, go to GAP.
  - GAP: inst_in_flg stays 0 for exactly one cycle, then go to IDLE. This guarantees at least one low cycle between requests.
  - mem_ret_flg is ignored in IDLE and GAP (a spurious or stale return is dropped).
- Queue space: only one request is ever outstanding, and it is issued only when count<DEPTH, so a push in WAIT can never overflow.
- npc = pc+4 by default (see Optional Feature). All PC arithmetic is 32-bit modulo; 0xFFFFFFFC+4 wraps to 0.
- Queue:
  - Circular buffer with head and tail indices of IQ_DEPTH_LOG bits (wrap naturally) and count of IQ_DEPTH_LOG+1 bits.
  - Push writes at tail, tail++.
  - Pop (iq_pop=1 and count>0) advances head. iq_pop while empty is ignored.
  - Push and pop in the same cycle leave count unchanged; both take effect.
  - iq_inst/iq_pc/iq_pred_pc reflect the head entry combinationally from the array; they are don't-care when iq_empty=1.
  - iq_empty = (count==0); iq_full = (count==DEPTH).
- Flush (clr=1, rdy=1) has highest priority:
  - pc<=clr_pc, head=tail=count=0, inst_in_flg<=0, go to GAP.
  - Any return and any pop in that cycle are discarded.
  - A flush in WAIT abandons the outstanding fetch; the memory controller is flushed by the same signal.
  - The first post-flush request is at clr_pc, two cycles after the flush edge.

Optional Feature:
- Macro FETCH_JAL_PREDICT_EN.
- Defined: when mem_ret_data[6:0]==7'b1101111 (JAL), npc = pc + sign_extend({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}). This value is written to iq_pred_pc and becomes the next fetch address. All other opcodes use pc+4.
- Not defined: npc = pc+4 for every instruction. iq_pred_pc is still present and always equals iq_pc+4.

Test Plan:
- Reset with RESET_PC=0, rdy=1, returns after 4 cycles with 0x00000013, 0x00100093 -> requests at 0x0 then 0x4. inst_in_flg is low for one GAP cycle between them. Queue holds (0x13, pc 0x0, pred 0x4), then (0x00100093, 0x4, 0x8).
- Never pop; always return 0x13 -> exactly 16 pushes, iq_full=1, no 17th request (inst_in_flg stays 0). Then one pop -> next request at pc 0x40.
- Flush in WAIT with clr_pc=0x200, mem_ret_flg=1 in the same cycle -> return dropped, queue empty. Next inst_in_flg rises with inst_addr=0x200 two cycles later.
- Push and pop in the same cycle at count=3 -> count remains 3, head entry advances. iq_pop while empty -> no change, iq_empty=1.
- rdy=0 for 5 cycles in WAIT with mem_ret_flg pulsing -> no push, pc unchanged, inst_in_flg/inst_addr held. Resumes normally afterwards.
- With FETCH_JAL_PREDICT_EN defined, pc=0x100 returns 0x0080006F -> iq_pred_pc=0x108, next request at 0x108. With the macro undefined -> iq_pred_pc=0x104, next request at 0x104.
